// File: rtl/mem_stage_if.sv
// mem_stage_if: external data-memory bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [15:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Mem_Ack;
  modport master (output Mem_Req, Mem_WE, Mem_Addr, Mem_WData, input Mem_RData, Mem_Ack);
  modport slave  (input Mem_Req, Mem_WE, Mem_Addr, Mem_WData, output Mem_RData, Mem_Ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage that freezes the pipe while a load/store waits on an
// external memory handshake, with a bounded wait that substitutes 32'hDEADBEEF on timeout.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  input  logic [3:0]  Dest,
  mem_stage_if.master mem,
  output logic        Freeze,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_Res_out,
  output logic [31:0] Mem_Data,
  output logic [3:0]  Dest_out,
  output logic        Mem_Err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d, wb_q, wb_d, rd_q, rd_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, data_q, data_d, res_q, res_d, mdata_q, mdata_d;
  logic [3:0]    dest_q, dest_d;
  logic          mem_op, tmo;
  assign mem_op = MEM_R_EN | MEM_W_EN;
  // Abort on the cycle whose increment would bring the count to TIMEOUT.
  assign tmo    = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    wb_d    = 1'b0;
    rd_d    = 1'b0;
    res_d   = res_q;
    mdata_d = mdata_q;
    dest_d  = dest_q;
    Freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          Freeze  = 1'b1;
          state_d = ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MEM_W_EN;
          addr_d  = 16'((ALU_Res - 32'd1024) >> 2);
          wdata_d = Val_Rm;
        end else begin
          wb_d    = WB_EN;
          rd_d    = MEM_R_EN;
          res_d   = ALU_Res;
          dest_d  = Dest;
        end
      end
      ACCESS: begin
        Freeze = 1'b1;
        if (mem.Mem_Ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          data_d  = we_q ? data_q : mem.Mem_RData;
        end else if (tmo) begin
          req_d   = 1'b0;
          state_d = DONE;
          data_d  = 32'hDEADBEEF;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        wb_d    = WB_EN;
        rd_d    = MEM_R_EN;
        res_d   = ALU_Res;
        mdata_d = data_q;
        dest_d  = Dest;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
      res_q   <= '0;
      mdata_q <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      mdata_q <= mdata_d;
      dest_q  <= dest_d;
    end
  end
  assign mem.Mem_Req   = req_q;
  assign mem.Mem_WE    = we_q;
  assign mem.Mem_Addr  = addr_q;
  assign mem.Mem_WData = wdata_q;
  assign WB_EN_out     = wb_q;
  assign MEM_R_EN_out  = rd_q;
  assign ALU_Res_out   = res_q;
  assign Mem_Data      = mdata_q;
  assign Dest_out      = dest_q;
  assign Mem_Err       = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: transaction-level model of the MEM stage driven by directed and random ops.
module tb_mem_stage;
  // Short timeout keeps abort cases brief while still admitting a 5-cycle store.
  localparam int TMO = 5;
  logic        clk = 1'b0, rst = 1'b0;
  logic        WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = '0, Val_Rm = '0;
  logic [3:0]  Dest = '0;
  logic        Freeze, WB_EN_out, MEM_R_EN_out, Mem_Err;
  logic [31:0] ALU_Res_out, Mem_Data;
  logic [3:0]  Dest_out;
  int          n_vec = 0, n_err = 0;
  logic [31:0] m_cap = '0, m_mdata = '0;
  logic        m_err = 1'b0;
  int          frz;
  mem_stage_if mem();
  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .mem(mem), .Freeze(Freeze),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
    .Mem_Data(Mem_Data), .Dest_out(Dest_out), .Mem_Err(Mem_Err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic wb, input logic rd, input logic wr,
                        input logic [31:0] res, input logic [31:0] vrm, input logic [3:0] d);
    WB_EN = wb; MEM_R_EN = rd; MEM_W_EN = wr; ALU_Res = res; Val_Rm = vrm; Dest = d;
  endtask
  task automatic run_nop(input logic wb, input logic [31:0] res, input logic [3:0] d, input logic stray);
    set_in(wb, 1'b0, 1'b0, res, $urandom, d);
    mem.Mem_Ack = stray; mem.Mem_RData = $urandom;
    #1 chk("nop_freeze", Freeze, 0);
    step;
    mem.Mem_Ack = 1'b0;
    chk("nop_wb", WB_EN_out, wb);
    chk("nop_rd", MEM_R_EN_out, 0);
    chk("nop_res", ALU_Res_out, res);
    chk("nop_dest", Dest_out, d);
    chk("nop_mdata", Mem_Data, m_mdata);
    chk("nop_req", mem.Mem_Req, 0);
    chk("nop_err", Mem_Err, m_err);
  endtask
  task automatic run_mem(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] res, input logic [31:0] vrm, input logic [3:0] d,
                         input int ack_at, input logic [31:0] rdata, output int fc);
    logic to;
    int n;
    logic [15:0] ea;
    to = ack_at < 1 || ack_at > TMO;
    n  = to ? TMO : ack_at;
    ea = 16'((res - 32'd1024) / 4);
    set_in(wb, rd, wr, res, vrm, d);
    mem.Mem_Ack = 1'($urandom_range(0, 1)); mem.Mem_RData = $urandom;
    #1 chk("idle_freeze", Freeze, 1);
    fc = int'(Freeze);
    step;
    mem.Mem_Ack = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk("acc_req", mem.Mem_Req, 1);
      chk("acc_we", mem.Mem_WE, wr);
      chk("acc_addr", mem.Mem_Addr, ea);
      chk("acc_wdata", mem.Mem_WData, vrm);
      chk("acc_bubble", {WB_EN_out, MEM_R_EN_out}, 0);
      chk("acc_err", Mem_Err, m_err);
      mem.Mem_Ack = !to && k == ack_at;
      mem.Mem_RData = mem.Mem_Ack ? rdata : $urandom;
      #1 chk("acc_freeze", Freeze, 1);
      fc += int'(Freeze);
      step;
      mem.Mem_Ack = 1'b0;
    end
    if (to) begin
      m_cap = 32'hDEADBEEF;
      m_err = 1'b1;
    end else if (!wr) m_cap = rdata;
    chk("done_req", mem.Mem_Req, 0);
    chk("done_freeze", Freeze, 0);
    chk("done_err", Mem_Err, m_err);
    mem.Mem_Ack = 1'($urandom_range(0, 1)); mem.Mem_RData = $urandom;
    step;
    mem.Mem_Ack = 1'b0;
    m_mdata = m_cap;
    chk("wb_wb", WB_EN_out, wb);
    chk("wb_rd", MEM_R_EN_out, rd);
    chk("wb_res", ALU_Res_out, res);
    chk("wb_dest", Dest_out, d);
    chk("wb_mdata", Mem_Data, m_mdata);
    chk("wb_req", mem.Mem_Req, 0);
  endtask
  initial begin
    logic rd, wr;
    mem.Mem_Ack = 1'b0; mem.Mem_RData = '0;
    #12;
    chk("rst_req", mem.Mem_Req, 0);
    chk("rst_addr", mem.Mem_Addr, 0);
    chk("rst_wdata", mem.Mem_WData, 0);
    chk("rst_wb", {WB_EN_out, MEM_R_EN_out, Mem_Err}, 0);
    chk("rst_res", ALU_Res_out, 0);
    chk("rst_mdata", Mem_Data, 0);
    chk("rst_dest", Dest_out, 0);
    MEM_R_EN = 1'b1;
    #1 chk("rst_freeze_op", Freeze, 1);
    MEM_R_EN = 1'b0;
    #1 chk("rst_freeze_nop", Freeze, 0);
    @(negedge clk) rst = 1'b1;
    step;
    run_nop(1'b1, 32'h10, 4'd3, 1'b0);
    run_mem(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5, 1, 32'hCAFE0001, frz);
    chk("load_freeze_cycles", frz, 2);
    chk("load_data", Mem_Data, 32'hCAFE0001);
    run_mem(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 4'd6, 5, 32'h0, frz);
    chk("store_freeze_cycles", frz, 6);
    run_mem(1'b1, 1'b1, 1'b0, 32'd2048, 32'h0, 4'd7, 0, 32'h0, frz);
    chk("tmo_freeze_cycles", frz, TMO + 1);
    chk("tmo_data", Mem_Data, 32'hDEADBEEF);
    chk("tmo_err", Mem_Err, 1);
    run_mem(1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd8, 2, 32'h5555AAAA, frz);
    run_mem(1'b0, 1'b0, 1'b1, 32'd1104, 32'hA5A5A5A5, 4'd9, 1, 32'h0, frz);
    chk("err_sticky", Mem_Err, 1);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        run_nop(1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
      else begin
        rd = 1'($urandom_range(0, 1));
        wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
        run_mem(1'($urandom_range(0, 1)), rd, wr, $urandom, $urandom, 4'($urandom),
                $urandom_range(1, TMO + 1), $urandom, frz);
      end
    end
    set_in(1'b1, 1'b1, 1'b0, 32'd4096, 32'h0, 4'd2);
    step;
    chk("mid_req", mem.Mem_Req, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", mem.Mem_Req, 0);
    chk("mid_rst_addr", mem.Mem_Addr, 0);
    chk("mid_rst_ctl", {WB_EN_out, MEM_R_EN_out, Mem_Err}, 0);
    chk("mid_rst_mdata", Mem_Data, 0);
    m_cap = '0; m_mdata = '0; m_err = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    #1 rst = 1'b1;
    mem.Mem_Ack = 1'b1; mem.Mem_RData = 32'hBAD0BAD0;
    step;
    mem.Mem_Ack = 1'b0;
    chk("post_req", mem.Mem_Req, 0);
    chk("post_freeze", Freeze, 0);
    chk("post_ctl", {WB_EN_out, MEM_R_EN_out, Mem_Err}, 0);
    chk("post_res", ALU_Res_out, 0);
    chk("post_mdata", Mem_Data, 0);
    run_mem(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1, 1, 32'h0BADF00D, frz);
    chk("post_load_freeze_cycles", frz, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
